// File: rtl/snake_body_streamer_pkg.sv
// Shared definitions for the snake body streamer.
//   GAME_WIDTH / GAME_HEIGHT : playfield size (border cells at 0 and SIZE+1)
//   X_W / Y_W                : coordinate widths derived from the playfield
//   dir_t                    : 2-bit move/segment direction code
//   state_t                  : streamer FSM states
//   pos_t                    : packed (x,y) cell coordinate
//   beat_t                   : one registered stream beat
//   opposite() / advance()   : direction reversal and one-cell move helpers
package snake_body_streamer_pkg;

  localparam int GAME_WIDTH  = 30;
  localparam int GAME_HEIGHT = 14;
  localparam int X_W         = $clog2(GAME_WIDTH + 2);
  localparam int Y_W         = $clog2(GAME_HEIGHT + 2);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_WALK = 1'b1
  } state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pos_t;

  typedef struct packed {
    pos_t pos;
    dir_t dir;
    logic first;
    logic last;
    logic valid;
  } beat_t;

  // Up/down and left/right differ only in bit 0.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'({d[1], ~d[0]});
  endfunction

  // One-cell move; coordinates wrap modulo their width, border handling is
  // left to the game controller.
  function automatic pos_t advance(input pos_t p, input dir_t d);
    pos_t r;
    r = p;
    case (d)
      DIR_UP:    r.y = p.y - Y_W'(1);
      DIR_DOWN:  r.y = p.y + Y_W'(1);
      DIR_LEFT:  r.x = p.x - X_W'(1);
      DIR_RIGHT: r.x = p.x + X_W'(1);
      default:   r   = p;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snake_body_streamer_dir_ram.sv
// Segment-direction ring buffer: MAX_LEN x 2-bit flop array.
//   clk, rst_n  : clock, asynchronous active-low reset (all entries -> LEFT)
//   clr_i       : synchronous clear (all entries -> LEFT)
//   ptr_i       : current head pointer; addresses are relative to it
//   rd_off_i    : segment index to read (0 = head)
//   rd_dir_o    : combinational read data
//   wr_en_i     : write the new head entry at (ptr_i - 1) mod MAX_LEN
//   wr_dir_i    : direction stored for the new head segment
module snake_body_streamer_dir_ram
  import snake_body_streamer_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int PTR_W  = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic [LEN_W-1:0] rd_off_i,
  output dir_t             rd_dir_o,
  input  logic             wr_en_i,
  input  dir_t             wr_dir_i
);

  localparam logic [LEN_W:0]   DEPTH  = (LEN_W + 1)'(MAX_LEN);
  localparam logic [LEN_W-1:0] WR_OFF = LEN_W'(MAX_LEN - 1);

  // (base + off) mod MAX_LEN; both operands are below MAX_LEN so one
  // conditional subtract suffices, and non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input logic [LEN_W-1:0] off);
    logic [LEN_W:0] sum;
    sum = (LEN_W + 1)'(base) + (LEN_W + 1)'(off);
    if (sum >= DEPTH) sum = sum - DEPTH;
    return PTR_W'(sum);
  endfunction

  dir_t             mem_q [MAX_LEN];
  logic [PTR_W-1:0] rd_addr;
  logic [PTR_W-1:0] wr_addr;

  assign rd_addr  = wrap_add(ptr_i, rd_off_i);
  assign wr_addr  = wrap_add(ptr_i, WR_OFF);
  assign rd_dir_o = mem_q[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= DIR_LEFT;
    end else if (clr_i) begin
      for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= DIR_LEFT;
    end else if (wr_en_i) begin
      mem_q[wr_addr] <= wr_dir_i;
    end
  end

endmodule

// File: rtl/snake_body_streamer.sv
// Snake body owner and head-to-tail segment streamer.
// Replays the body one segment per cycle (WALK), then idles one cycle (GAP)
// where a move/grow step may be accepted, so a pass is never torn.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   game_rst_n          : synchronous active-low game restart
//   step_valid/ready    : step handshake (ready only in GAP)
//   step_dir, step_grow : move direction, keep-tail flag
//   snake_x/y/dir       : stream beat position and tailward direction
//   snake_first/last    : head / tail markers; snake_valid: beat valid
//   snake_head_x/y      : current head; length, full: body length status
//   collision           : head overlaps body (SNAKE_SELF_COLLISION_EN build)
// Optional feature macro: SNAKE_SELF_COLLISION_EN (undefined: collision = 0).
module snake_body_streamer
  import snake_body_streamer_pkg::*;
#(
  parameter int MAX_LEN   = 64,
  parameter int START_X   = 4,
  parameter int START_Y   = 7,
  parameter int START_LEN = 3,
  localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             game_rst_n,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic [1:0]       step_dir,
  input  logic             step_grow,
  output logic [X_W-1:0]   snake_x,
  output logic [Y_W-1:0]   snake_y,
  output logic [1:0]       snake_dir,
  output logic             snake_first,
  output logic             snake_last,
  output logic             snake_valid,
  output logic [X_W-1:0]   snake_head_x,
  output logic [Y_W-1:0]   snake_head_y,
  output logic [LEN_W-1:0] length,
  output logic             full,
  output logic             collision
);

  localparam int               PTR_W     = $clog2(MAX_LEN);
  localparam pos_t             START_POS = '{x: X_W'(START_X), y: Y_W'(START_Y)};
  localparam logic [LEN_W-1:0] START_L   = LEN_W'(START_LEN);
  localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_LEN);

  state_t           state_q, state_d;
  pos_t             head_q, head_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0] idx_q, idx_d;    // index of the next beat to load
  pos_t             walk_q, walk_d;  // position of the next beat to load
  beat_t            beat_q, beat_d;
  logic             accept;
  dir_t             rd_dir, eff_dir, wr_dir;

  assign full   = (len_q == MAX_L);
  assign wr_dir = opposite(eff_dir);

  // idx_q is 0 throughout GAP, so rd_dir is then the neck direction (seg 0).
  snake_body_streamer_dir_ram #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_dir_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!game_rst_n),
    .ptr_i    (ptr_q),
    .rd_off_i (idx_q),
    .rd_dir_o (rd_dir),
    .wr_en_i  (accept),
    .wr_dir_i (wr_dir)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           state_q <= ST_GAP;
    else if (!game_rst_n) state_q <= ST_GAP;
    else                  state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_GAP:  state_d = ST_WALK;
      ST_WALK: if (beat_q.last) state_d = ST_GAP;
      default: state_d = ST_GAP;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    step_ready = (state_q == ST_GAP);
    accept     = step_valid && step_ready;
    // Stepping into the neck is turned into "keep going straight".
    eff_dir    = (dir_t'(step_dir) == rd_dir) ? opposite(rd_dir) : dir_t'(step_dir);
    head_d     = head_q;
    len_d      = len_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    walk_d     = walk_q;
    beat_d     = '0;
    case (state_q)
      ST_GAP: begin
        if (accept) begin
          head_d = advance(head_q, eff_dir);
          ptr_d  = (ptr_q == '0) ? PTR_W'(MAX_LEN - 1) : ptr_q - PTR_W'(1);
          if (step_grow && !full) len_d = len_q + LEN_W'(1);
        end
        // Beat 0 is loaded on the same edge as the step, so it must use the
        // post-step head and new head direction rather than the RAM contents.
        beat_d.pos   = head_d;
        beat_d.dir   = accept ? wr_dir : rd_dir;
        beat_d.first = 1'b1;
        beat_d.last  = (len_d == LEN_W'(1));
        beat_d.valid = 1'b1;
        walk_d       = advance(head_d, beat_d.dir);
        idx_d        = LEN_W'(1);
      end
      ST_WALK: begin
        if (beat_q.last) begin
          idx_d = '0;
        end else begin
          beat_d.pos   = walk_q;
          beat_d.dir   = rd_dir;
          beat_d.first = 1'b0;
          beat_d.last  = (idx_q == len_q - LEN_W'(1));
          beat_d.valid = 1'b1;
          walk_d       = advance(walk_q, rd_dir);
          idx_d        = idx_q + LEN_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= START_POS;
      len_q  <= START_L;
      ptr_q  <= '0;
      idx_q  <= '0;
      walk_q <= '0;
      beat_q <= '0;
    end else if (!game_rst_n) begin
      head_q <= START_POS;
      len_q  <= START_L;
      ptr_q  <= '0;
      idx_q  <= '0;
      walk_q <= '0;
      beat_q <= '0;
    end else begin
      head_q <= head_d;
      len_q  <= len_d;
      ptr_q  <= ptr_d;
      idx_q  <= idx_d;
      walk_q <= walk_d;
      beat_q <= beat_d;
    end
  end

  assign snake_x      = beat_q.pos.x;
  assign snake_y      = beat_q.pos.y;
  assign snake_dir    = beat_q.dir;
  assign snake_first  = beat_q.first;
  assign snake_last   = beat_q.last;
  assign snake_valid  = beat_q.valid;
  assign snake_head_x = head_q.x;
  assign snake_head_y = head_q.y;
  assign length       = len_q;

`ifdef SNAKE_SELF_COLLISION_EN
  // Compare the displayed beat against the head; head and tail beats are
  // excluded (the tail cell is vacated by the next move).
  logic hit_q;
  logic collision_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q       <= 1'b0;
      collision_q <= 1'b0;
    end else if (!game_rst_n) begin
      hit_q       <= 1'b0;
      collision_q <= 1'b0;
    end else if (state_q == ST_WALK) begin
      if (beat_q.last) begin
        collision_q <= hit_q;
        hit_q       <= 1'b0;
      end else if (!beat_q.first && (beat_q.pos == head_q)) begin
        hit_q <= 1'b1;
      end
    end
  end

  assign collision = collision_q;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_snake_body_streamer.sv
module tb_snake_body_streamer;

  localparam int MAX_LEN = 7;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             game_rst_n = 1'b1;
  logic             step_valid = 1'b0;
  logic             step_ready;
  logic [1:0]       step_dir = 2'd0;
  logic             step_grow = 1'b0;
  logic [4:0]       snake_x;
  logic [3:0]       snake_y;
  logic [1:0]       snake_dir;
  logic             snake_first, snake_last, snake_valid;
  logic [4:0]       snake_head_x;
  logic [3:0]       snake_head_y;
  logic [LEN_W-1:0] length;
  logic             full, collision;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: head cell plus list of segment directions, head first.
  logic [4:0] m_hx;
  logic [3:0] m_hy;
  logic [1:0] m_dirs[$];

  snake_body_streamer #(
    .MAX_LEN   (MAX_LEN),
    .START_X   (4),
    .START_Y   (7),
    .START_LEN (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .game_rst_n   (game_rst_n),
    .step_valid   (step_valid),
    .step_ready   (step_ready),
    .step_dir     (step_dir),
    .step_grow    (step_grow),
    .snake_x      (snake_x),
    .snake_y      (snake_y),
    .snake_dir    (snake_dir),
    .snake_first  (snake_first),
    .snake_last   (snake_last),
    .snake_valid  (snake_valid),
    .snake_head_x (snake_head_x),
    .snake_head_y (snake_head_y),
    .length       (length),
    .full         (full),
    .collision    (collision)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] opp(input logic [1:0] d);
    case (d)
      2'd0:    return 2'd1;
      2'd1:    return 2'd0;
      2'd2:    return 2'd3;
      default: return 2'd2;
    endcase
  endfunction

  task automatic move(inout logic [4:0] x, inout logic [3:0] y, input logic [1:0] d);
    case (d)
      2'd0:    y = y - 4'd1;
      2'd1:    y = y + 4'd1;
      2'd2:    x = x - 5'd1;
      default: x = x + 5'd1;
    endcase
  endtask

  task automatic model_reset();
    m_hx = 5'd4;
    m_hy = 4'd7;
    m_dirs.delete();
    repeat (3) m_dirs.push_back(2'd2);
  endtask

  task automatic model_step(input logic [1:0] d, input logic grow);
    logic [1:0] eff;
    int         old_len;
    old_len = m_dirs.size();
    eff = (d == m_dirs[0]) ? opp(m_dirs[0]) : d;
    move(m_hx, m_hy, eff);
    m_dirs.push_front(opp(eff));
    if (!(grow && old_len < MAX_LEN)) void'(m_dirs.pop_back());
  endtask

  // Follows one full pass from its first beat, then checks the gap cycle.
  task automatic check_pass(input bit check_period);
    int         waited;
    int         len;
    logic [4:0] x;
    logic [3:0] y;
    logic       hit, exp_col, exp_first, exp_last;
    waited = 0;
    while (!(snake_valid === 1'b1 && snake_first === 1'b1) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pass_start: no first beat within 40 cycles, required one");
      return;
    end
    if (check_period) begin
      n_cmp++;
      if (waited !== 1) begin
        n_bad++;
        $display("FAIL period: gap of %0d cycles, required 1", waited);
      end
    end
    len = m_dirs.size();
    x   = m_hx;
    y   = m_hy;
    hit = 1'b0;
    for (int i = 0; i < len; i++) begin
      exp_first = (i == 0);
      exp_last  = (i == len - 1);
      n_cmp++;
      if ({snake_valid, snake_x, snake_y, snake_dir, snake_first, snake_last} !==
          {1'b1, x, y, m_dirs[i], exp_first, exp_last}) begin
        n_bad++;
        $display("FAIL beat%0d: got v=%0b (%0d,%0d) d=%0d f=%0b l=%0b, required v=1 (%0d,%0d) d=%0d f=%0b l=%0b",
                 i, snake_valid, snake_x, snake_y, snake_dir, snake_first, snake_last,
                 x, y, m_dirs[i], exp_first, exp_last);
      end
      if (i >= 1 && i <= len - 2 && x == m_hx && y == m_hy) hit = 1'b1;
      move(x, y, m_dirs[i]);
      @(negedge clk);
    end
    exp_col = hit;
`ifndef SNAKE_SELF_COLLISION_EN
    exp_col = 1'b0;
`endif
    n_cmp++;
    if ({snake_valid, step_ready, collision, full, length, snake_head_x, snake_head_y} !==
        {1'b0, 1'b1, exp_col, (len == MAX_LEN), LEN_W'(len), m_hx, m_hy}) begin
      n_bad++;
      $display("FAIL gap: got v=%0b rdy=%0b col=%0b full=%0b len=%0d head=(%0d,%0d), required v=0 rdy=1 col=%0b full=%0b len=%0d head=(%0d,%0d)",
               snake_valid, step_ready, collision, full, length, snake_head_x, snake_head_y,
               exp_col, (len == MAX_LEN), len, m_hx, m_hy);
    end
    $display("pass len=%0d head=(%0d,%0d) collision=%0b", len, m_hx, m_hy, collision);
  endtask

  task automatic do_step(input logic [1:0] d, input logic grow, input int delay);
    int waited;
    repeat (delay) @(negedge clk);
    step_dir   = d;
    step_grow  = grow;
    step_valid = 1'b1;
    waited     = 0;
    while (step_ready !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL step_ready: not seen within 40 cycles, required 1");
      step_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    step_valid = 1'b0;
    model_step(d, grow);
    n_cmp++;
    if ({snake_head_x, snake_head_y, length} !== {m_hx, m_hy, LEN_W'(m_dirs.size())}) begin
      n_bad++;
      $display("FAIL step_head: got (%0d,%0d) len=%0d, required (%0d,%0d) len=%0d",
               snake_head_x, snake_head_y, length, m_hx, m_hy, m_dirs.size());
    end
    $display("step dir=%0d grow=%0b head=(%0d,%0d) len=%0d", d, grow, m_hx, m_hy, m_dirs.size());
  endtask

  // Caller is positioned on a negative edge.
  task automatic game_restart();
    game_rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({snake_valid, snake_head_x, snake_head_y, length, collision, step_ready} !==
        {1'b0, 5'd4, 4'd7, LEN_W'(3), 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL game_restart: got v=%0b head=(%0d,%0d) len=%0d col=%0b rdy=%0b, required v=0 head=(4,7) len=3 col=0 rdy=1",
               snake_valid, snake_head_x, snake_head_y, length, collision, step_ready);
    end
    game_rst_n = 1'b1;
    model_reset();
    $display("game restart");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({snake_valid, snake_x, snake_y, snake_dir, snake_first, snake_last,
         snake_head_x, snake_head_y, length, full, collision, step_ready} !==
        {1'b0, 5'd0, 4'd0, 2'd0, 1'b0, 1'b0, 5'd4, 4'd7, LEN_W'(3), 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset: got v=%0b (%0d,%0d) d=%0d f=%0b l=%0b head=(%0d,%0d) len=%0d full=%0b col=%0b rdy=%0b, required zeros head=(4,7) len=3 rdy=1",
               snake_valid, snake_x, snake_y, snake_dir, snake_first, snake_last,
               snake_head_x, snake_head_y, length, full, collision, step_ready);
    end
    rst_n = 1'b1;
    model_reset();
    check_pass(1'b0);
    check_pass(1'b1);
  endtask

  task automatic test_step_straight();
    do_step(2'd3, 1'b0, 0);
    check_pass(1'b0);
  endtask

  task automatic test_grow();
    do_step(2'd0, 1'b1, 0);
    check_pass(1'b0);
  endtask

  task automatic test_reversal();
    game_restart();
    check_pass(1'b0);
    do_step(2'd2, 1'b0, 0);
    n_cmp++;
    if ({snake_head_x, snake_head_y} !== {5'd5, 4'd7}) begin
      n_bad++;
      $display("FAIL reversal: got head (%0d,%0d), required (5,7)", snake_head_x, snake_head_y);
    end
    check_pass(1'b0);
  endtask

  task automatic test_full();
    game_restart();
    for (int i = 0; i < MAX_LEN - 3 + 2; i++) begin
      do_step(2'($urandom_range(0, 3)), 1'b1, 0);
      check_pass(1'b0);
    end
  endtask

  task automatic test_mid_pass_restart();
    int waited;
    waited = 0;
    while (!(snake_valid === 1'b1 && snake_first === 1'b0) && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL mid_pass: no mid-pass beat within 40 cycles, required one");
    end
    game_restart();
    check_pass(1'b0);
    check_pass(1'b1);
  endtask

  task automatic test_collision();
    game_restart();
    check_pass(1'b0);
    do_step(2'd0, 1'b1, 0);
    check_pass(1'b0);
    do_step(2'd3, 1'b1, 0);
    check_pass(1'b0);
    do_step(2'd1, 1'b1, 0);
    check_pass(1'b0);
    do_step(2'd2, 1'b0, 0);
    check_pass(1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      do_step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), $urandom_range(0, 4));
      check_pass(1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_step_straight();
    test_grow();
    test_reversal();
    test_full();
    test_mid_pass_restart();
    test_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
